// File: rtl/ifft_pkg.sv
// Shared definitions for the IFFT_CP SDF stage controllers.
//   state_e   : stage sequencer states
//   branch_e  : butterfly / delay-branch index encoding
//   cfg_legal : elaboration-time legality check of N / D / ADDR_W
package ifft_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StFill,
    StRun,
    StFlush,
    StDone
  } state_e;

  // Branches 0..2 live in delay lines; branch 3 is the sample that fires the butterfly.
  typedef enum logic [1:0] {
    Branch0,
    Branch1,
    Branch2,
    Branch3
  } branch_e;

  // D must be a power of two, N a power of two multiple of 4*D, and ADDR_W wide enough for N.
  function automatic bit cfg_legal(int unsigned n, int unsigned d, int unsigned addr_w);
    return (d >= 1) && ((d & (d - 1)) == 0) && ((n % (4 * d)) == 0) &&
           ((n & (n - 1)) == 0) && ($clog2(n) <= addr_w);
  endfunction

endpackage

// File: rtl/r4_tw_addr_gen.sv
// Incremental twiddle-address generator for one radix-4 SDF stage.
// Produces (branch * idx * TW_STRIDE) mod N without a multiplier by accumulating
// branch*TW_STRIDE per output and restarting at every idx wrap.
//   clk, rst : clock, async active-low reset
//   en       : an output is produced this cycle; commit the accumulator
//   clr      : current idx is 0 (restart the accumulation)
//   branch   : butterfly output branch 0..3
//   tw_addr  : address for the current output (combinational, registered by the caller)
module r4_tw_addr_gen #(
  parameter int unsigned N         = 2048,
  parameter int unsigned TW_STRIDE = 2,
  parameter int unsigned ADDR_W    = 12
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              clr,
  input  logic [1:0]        branch,
  output logic [ADDR_W-1:0] tw_addr
);

  // N is a power of two, so mod N is a mask of the low log2(N) bits.
  localparam logic [ADDR_W-1:0] WrapMask = ADDR_W'(N - 1);

  logic [ADDR_W-1:0] acc_q;
  logic [ADDR_W-1:0] step;

  always_comb begin
    step = '0;
    unique case (branch)
      2'd0: step = '0;
      2'd1: step = ADDR_W'(TW_STRIDE);
      2'd2: step = ADDR_W'(2 * TW_STRIDE);
      2'd3: step = ADDR_W'(3 * TW_STRIDE);
      default: step = '0;
    endcase
  end

  always_comb begin
    tw_addr = clr ? '0 : ((acc_q + step) & WrapMask);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      acc_q <= '0;
    end else if (en) begin
      acc_q <= tw_addr;
    end
  end

endmodule

// File: rtl/r4_sdf_stage_ctrl.sv
// Sequencer for one radix-4 single-path delay-feedback stage.
// Counts accepted samples, steers them into delay branches 0..2 or fires the butterfly,
// tags every butterfly output with its branch and twiddle address, and frames one
// N-point block as FILL -> RUN -> FLUSH -> DONE. All outputs are registered and describe
// the sample accepted (or flush slot processed) on the preceding edge.
//   clk, rst    : clock, async active-low reset
//   start       : arms a frame (honoured only in IDLE)
//   in_valid    : input sample present;  in_ready : controller accepts samples
//   dl_wr_en    : write sample to branch dl_sel at slot dl_idx
//   bf_en       : butterfly fires
//   out_valid   : butterfly output present, branch out_branch, twiddle address tw_addr
//   frame_done  : one-cycle pulse after the last output of a frame
module r4_sdf_stage_ctrl
  import ifft_pkg::*;
#(
  parameter int unsigned N         = 2048,
  parameter int unsigned D         = 256,
  parameter int unsigned TW_STRIDE = 2,
  parameter int unsigned ADDR_W    = 12
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              dl_wr_en,
  output logic [1:0]        dl_sel,
  output logic [ADDR_W-1:0] dl_idx,
  output logic              bf_en,
  output logic              out_valid,
  output logic [1:0]        out_branch,
  output logic [ADDR_W-1:0] tw_addr,
  output logic              frame_done
);

  if (!cfg_legal(N, D, ADDR_W)) begin : gen_cfg_check
    $error("r4_sdf_stage_ctrl: illegal N/D/ADDR_W combination");
  end

  localparam int unsigned       LogD       = $clog2(D);
  localparam logic [ADDR_W-1:0] IdxMask    = ADDR_W'(D - 1);
  localparam logic [ADDR_W-1:0] LastFill   = ADDR_W'(3 * D - 1);
  localparam logic [ADDR_W-1:0] LastSample = ADDR_W'(N - 1);

  state_e            state_q;
  // Sample counter in FILL/RUN; reused as the flush slot counter in FLUSH.
  logic [ADDR_W-1:0] cnt_q;
  logic [ADDR_W-1:0] cur_idx;
  logic [1:0]        cur_phase;
  logic              tw_en;
  logic              tw_clr;
  logic [ADDR_W-1:0] tw_next;

  always_comb begin
    cur_idx   = cnt_q & IdxMask;
    cur_phase = cnt_q[LogD +: 2];
    tw_en     = ((state_q == StRun) && in_valid) || (state_q == StFlush);
    tw_clr    = (cur_idx == '0);
  end

  r4_tw_addr_gen #(
    .N         (N),
    .TW_STRIDE (TW_STRIDE),
    .ADDR_W    (ADDR_W)
  ) u_tw_addr_gen (
    .clk     (clk),
    .rst     (rst),
    .en      (tw_en),
    .clr     (tw_clr),
    .branch  (cur_phase),
    .tw_addr (tw_next)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      in_ready   <= 1'b0;
      dl_wr_en   <= 1'b0;
      dl_sel     <= '0;
      dl_idx     <= '0;
      bf_en      <= 1'b0;
      out_valid  <= 1'b0;
      out_branch <= '0;
      tw_addr    <= '0;
      frame_done <= 1'b0;
    end else begin
      // Per-sample outputs are pulses; anything not driven below goes quiet.
      dl_wr_en   <= 1'b0;
      dl_sel     <= '0;
      dl_idx     <= '0;
      bf_en      <= 1'b0;
      out_valid  <= 1'b0;
      out_branch <= '0;
      tw_addr    <= '0;
      frame_done <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (start) begin
            state_q  <= StFill;
            cnt_q    <= '0;
            in_ready <= 1'b1;
          end
        end
        StFill: begin
          if (in_valid) begin
            dl_wr_en <= 1'b1;
            dl_sel   <= cur_phase;
            dl_idx   <= cur_idx;
            cnt_q    <= cnt_q + ADDR_W'(1);
            if (cnt_q == LastFill) begin
              state_q <= StRun;
            end
          end
        end
        StRun: begin
          if (in_valid) begin
            dl_idx     <= cur_idx;
            out_valid  <= 1'b1;
            out_branch <= cur_phase;
            tw_addr    <= tw_next;
            if (cur_phase == Branch3) begin
              bf_en <= 1'b1;
            end else begin
              // Branch slot is read out and overwritten by the incoming sample.
              dl_wr_en <= 1'b1;
              dl_sel   <= cur_phase;
            end
            if (cnt_q == LastSample) begin
              state_q  <= StFlush;
              cnt_q    <= '0;
              in_ready <= 1'b0;
            end else begin
              cnt_q <= cnt_q + ADDR_W'(1);
            end
          end
        end
        StFlush: begin
          out_valid  <= 1'b1;
          out_branch <= cur_phase;
          dl_idx     <= cur_idx;
          tw_addr    <= tw_next;
          if (cnt_q == LastFill) begin
            state_q <= StDone;
            cnt_q   <= '0;
          end else begin
            cnt_q <= cnt_q + ADDR_W'(1);
          end
        end
        StDone: begin
          frame_done <= 1'b1;
          state_q    <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_r4_sdf_stage_ctrl.sv
module tb_r4_sdf_stage_ctrl;

  localparam int unsigned N  = 64;
  localparam int unsigned D  = 4;
  localparam int unsigned S  = 4;
  localparam int unsigned AW = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          start = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic          dl_wr_en;
  logic [1:0]    dl_sel;
  logic [AW-1:0] dl_idx;
  logic          bf_en;
  logic          out_valid;
  logic [1:0]    out_branch;
  logic [AW-1:0] tw_addr;
  logic          frame_done;

  always #5 clk = ~clk;

  r4_sdf_stage_ctrl #(
    .N         (N),
    .D         (D),
    .TW_STRIDE (S),
    .ADDR_W    (AW)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .dl_wr_en   (dl_wr_en),
    .dl_sel     (dl_sel),
    .dl_idx     (dl_idx),
    .bf_en      (bf_en),
    .out_valid  (out_valid),
    .out_branch (out_branch),
    .tw_addr    (tw_addr),
    .frame_done (frame_done)
  );

  typedef struct packed {
    logic          wr;
    logic [1:0]    sel;
    logic [AW-1:0] idx;
    logic          bf;
    logic          ov;
    logic [1:0]    br;
    logic [AW-1:0] tw;
    logic          fd;
  } ev_t;

  ev_t exp_q[$];
  int  checks = 0;
  int  failures = 0;
  bit  mon_en = 1'b0;
  int  frame_outs = 0;
  int  frames_done = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: a butterfly output of branch b at slot i carries twiddle (b*i*S) mod N.
  function automatic ev_t mk_out(int b, int i);
    ev_t e = '0;
    e.ov  = 1'b1;
    e.br  = 2'(b);
    e.idx = AW'(i);
    e.tw  = AW'((b * i * S) % N);
    return e;
  endfunction

  function automatic ev_t model_sample(int k);
    int  i  = k % D;
    int  ph = (k / D) % 4;
    ev_t e  = '0;
    if (k < 3 * D) begin
      e.wr  = 1'b1;
      e.sel = 2'(ph);
      e.idx = AW'(i);
    end else begin
      e = mk_out(ph, i);
      if (ph == 3) e.bf = 1'b1;
      else begin
        e.wr  = 1'b1;
        e.sel = 2'(ph);
      end
    end
    return e;
  endfunction

  function automatic ev_t dut_ev();
    ev_t e;
    e.wr  = dl_wr_en;
    e.sel = dl_sel;
    e.idx = dl_idx;
    e.bf  = bf_en;
    e.ov  = out_valid;
    e.br  = out_branch;
    e.tw  = tw_addr;
    e.fd  = frame_done;
    return e;
  endfunction

  // Monitor: pops one expectation per cycle in which the DUT presents anything.
  always @(negedge clk) begin
    if (rst && mon_en && (dl_wr_en || bf_en || out_valid || frame_done)) begin
      if (exp_q.size() == 0) begin
        check("unexpected_output", 32'(dut_ev()), 32'd0);
      end else begin
        check("event", 32'(dut_ev()), 32'(exp_q.pop_front()));
      end
      if (out_valid) frame_outs++;
      if (frame_done) begin
        check("done_not_ready", 32'(in_ready), 32'd0);
        check("frame_out_count", 32'(frame_outs), 32'(N));
        frame_outs = 0;
        frames_done++;
      end
    end
  end

  task automatic feed(input int stall_at, input int abort_at, output bit aborted);
    int k = 0;
    int cyc = 0;
    int stall_left = 0;
    bit stalled = 1'b0;
    aborted = 1'b0;
    while (k < N && cyc < 4000 && !aborted) begin
      @(negedge clk);
      cyc++;
      start = ($urandom_range(0, 7) == 0);
      if (k == stall_at && !stalled) begin
        stalled = 1'b1;
        stall_left = 5;
      end
      if (stall_left > 0) begin
        if (stall_left < 5) check("stall_quiet", {29'd0, out_valid, dl_wr_en, bf_en}, 32'd0);
        in_valid = 1'b0;
        stall_left--;
      end else begin
        in_valid = ($urandom_range(0, 3) != 0);
      end
      if (in_valid && in_ready) begin
        exp_q.push_back(model_sample(k));
        k++;
      end
      if (k == abort_at) aborted = 1'b1;
    end
    if (!aborted) check("feed_complete", 32'(k), 32'(N));
  endtask

  task automatic finish_frame(input bit hold_start);
    bit  seen = 1'b0;
    int  cyc = 0;
    ev_t e = '0;
    for (int f = 0; f < 3 * D; f++) exp_q.push_back(mk_out(f / D, f % D));
    e.fd = 1'b1;
    exp_q.push_back(e);
    while (!seen && cyc < 3 * D + 20) begin
      @(negedge clk);
      cyc++;
      start = hold_start;
      in_valid = ($urandom_range(0, 1) == 1);
      if (frame_done) seen = 1'b1;
    end
    check("frame_done_seen", 32'(seen), 32'd1);
    @(negedge clk);
    start = 1'b0;
    in_valid = 1'b0;
    check("ready_after_done", 32'(in_ready), 32'(hold_start));
  endtask

  initial begin
    bit aborted;
    #2;
    repeat (2) @(negedge clk);
    check("reset_state", {7'd0, in_ready, dut_ev()}, 32'd0);
    rst = 1'b1;
    mon_en = 1'b1;

    // Frame A: random valids, 5-cycle stall inside RUN, start held through FLUSH/DONE.
    @(negedge clk);
    start = 1'b1;
    in_valid = 1'b1;
    feed(20, -1, aborted);
    finish_frame(1'b1);

    // Frame B (started by the held start in IDLE): abort by reset mid-RUN.
    feed(-1, 30, aborted);
    check("abort_taken", 32'(aborted), 32'd1);
    @(posedge clk);
    #2;
    mon_en = 1'b0;
    rst = 1'b0;
    start = 1'b0;
    in_valid = 1'b0;
    #1;
    check("reset_clears", {7'd0, in_ready, dut_ev()}, 32'd0);
    exp_q.delete();
    frame_outs = 0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    mon_en = 1'b1;
    repeat (5) begin
      @(negedge clk);
      in_valid = 1'b1;
      check("idle_after_reset", {30'd0, in_ready, frame_done}, 32'd0);
    end

    // Frame C: fresh frame from IDLE must restart at sample 0.
    @(negedge clk);
    start = 1'b1;
    in_valid = 1'b0;
    feed(-1, -1, aborted);
    finish_frame(1'b0);
    repeat (10) @(negedge clk);
    check("queue_empty", 32'(exp_q.size()), 32'd0);
    check("frames_done", 32'(frames_done), 32'd2);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1, "watchdog");
  end

endmodule
